// File: rtl/uart_rx_frac.sv
`timescale 1ns/1ps
// uart_rx_frac: UART receiver. A fractional phase accumulator makes the
// oversample tick, each bit value is a 3-sample majority vote around mid-bit,
// and one received word is held behind a valid/ready handshake with a sticky
// overrun flag.
// Optional feature: define UART_RX_PARITY_EN to receive and check one parity
// bit after the data bits.
module uart_rx_frac #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 115200,
  parameter int OVS       = 16,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_pin,
  input  logic                 parity_odd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  // Rounded increment: BAUD_RATE*OVS*2^32/CLK_FREQ, evaluated in 64 bits.
  localparam logic [63:0] INC_WIDE =
    (((64'(BAUD_RATE) * 64'(OVS)) << 32) + (64'(CLK_FREQ) >> 1)) / 64'(CLK_FREQ);
  localparam logic [31:0] INC       = INC_WIDE[31:0];
  localparam logic [3:0]  T_S0      = 4'(OVS / 2 - 1);
  localparam logic [3:0]  T_S1      = 4'(OVS / 2);
  localparam logic [3:0]  T_VOTE    = 4'(OVS / 2 + 1);
  localparam logic [3:0]  T_LAST    = 4'(OVS - 1);
  localparam logic [3:0]  BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

`ifdef UART_RX_PARITY_EN
  // 1 means the data, parity bit and parity mode disagree.
  function automatic logic parity_calc(input logic [DATA_BITS-1:0] d,
                                       input logic p, input logic odd);
    return (^d) ^ p ^ odd;
  endfunction
`endif

  logic [31:0]          acc_r;
  logic [32:0]          acc_sum_s;
  logic                 tick_s;
  logic                 sync1_r, sync2_r, rx_s;
  state_t               state_r, state_next_s;
  logic [3:0]           tick_cnt_r, bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 samp_a_r, samp_b_r, ferr_acc_r;
  logic                 vote_s, at_vote_s, bit_end_s, done_s, load_s, hs_s;
  logic                 frame_err_s, parity_err_s;
  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_valid_r, frame_err_r, parity_err_r, overrun_r, busy_r;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit_r;
`else
  logic                 unused_parity_odd_s;
  assign unused_parity_odd_s = parity_odd;
`endif

  assign acc_sum_s = {1'b0, acc_r} + {1'b0, INC};
  assign tick_s    = acc_sum_s[32];
  assign rx_s      = sync2_r;
  assign at_vote_s = tick_s && (tick_cnt_r == T_VOTE);
  assign bit_end_s = tick_s && (tick_cnt_r == T_LAST);
  assign vote_s    = maj3(samp_a_r, samp_b_r, rx_s);

  // Phase accumulator; its carry out is the oversample tick.
  always_ff @(posedge clk) begin
    if (reset) acc_r <= 32'd0;
    else       acc_r <= acc_sum_s[31:0];
  end

  // Two-flop synchronizer for the asynchronous line, idling high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= rx_pin;
      sync2_r <= sync1_r;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_next_s;
  end

  // Next-state logic; a frame completes at the last stop bit's vote point.
  always_comb begin
    state_next_s = state_r;
    done_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tick_s && !rx_s) state_next_s = ST_START;
        else                  state_next_s = ST_IDLE;
      end
      ST_START: begin
        if (at_vote_s && vote_s) state_next_s = ST_IDLE;
        else if (bit_end_s)      state_next_s = ST_DATA;
        else                     state_next_s = ST_START;
      end
      ST_DATA: begin
`ifdef UART_RX_PARITY_EN
        if (bit_end_s && (bit_cnt_r == BIT_LAST)) state_next_s = ST_PARITY;
`else
        if (bit_end_s && (bit_cnt_r == BIT_LAST)) state_next_s = ST_STOP;
`endif
        else                                      state_next_s = ST_DATA;
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (bit_end_s) state_next_s = ST_STOP;
        else           state_next_s = ST_PARITY;
      end
`endif
      ST_STOP: begin
        if (at_vote_s && (bit_cnt_r == STOP_LAST)) begin
          state_next_s = ST_IDLE;
          done_s       = 1'b1;
        end else begin
          state_next_s = ST_STOP;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode: handshake, load decision and the flags of the finished word.
  always_comb begin
    hs_s        = rx_valid_r && rx_ready;
    load_s      = done_s && (!rx_valid_r || rx_ready);
    frame_err_s = ferr_acc_r | ~vote_s;
`ifdef UART_RX_PARITY_EN
    parity_err_s = parity_calc(shift_r, par_bit_r, parity_odd);
`else
    parity_err_s = 1'b0;
`endif
  end

  // Bit timing, sampling, data shifting and stop-bit error accumulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_r <= 4'd0;
      bit_cnt_r  <= 4'd0;
      shift_r    <= '0;
      samp_a_r   <= 1'b1;
      samp_b_r   <= 1'b1;
      ferr_acc_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_r  <= 1'b0;
`endif
    end else if (state_r == ST_IDLE) begin
      tick_cnt_r <= 4'd0;
      bit_cnt_r  <= 4'd0;
      ferr_acc_r <= 1'b0;
    end else if (tick_s) begin
      tick_cnt_r <= bit_end_s ? 4'd0 : tick_cnt_r + 4'd1;
      if (tick_cnt_r == T_S0) samp_a_r <= rx_s;
      if (tick_cnt_r == T_S1) samp_b_r <= rx_s;
      if (at_vote_s) begin
        case (state_r)
          ST_DATA:   shift_r <= {vote_s, shift_r[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
          ST_PARITY: par_bit_r <= vote_s;
`endif
          ST_STOP:   if (!vote_s) ferr_acc_r <= 1'b1;
          default:   ;
        endcase
      end
      if (bit_end_s) begin
        case (state_r)
          ST_DATA: bit_cnt_r <= (bit_cnt_r == BIT_LAST) ? 4'd0 : bit_cnt_r + 4'd1;
          ST_STOP: bit_cnt_r <= bit_cnt_r + 4'd1;
          default: ;
        endcase
      end
    end
  end

  // Held word, valid handshake, sticky overrun and busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data_r    <= '0;
      rx_valid_r   <= 1'b0;
      frame_err_r  <= 1'b0;
      parity_err_r <= 1'b0;
      overrun_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      if (load_s) begin
        rx_data_r    <= shift_r;
        frame_err_r  <= frame_err_s;
        parity_err_r <= parity_err_s;
        rx_valid_r   <= 1'b1;
      end else if (hs_s) begin
        rx_valid_r   <= 1'b0;
      end
      if (done_s && rx_valid_r && !rx_ready) overrun_r <= 1'b1;
      else if (hs_s && !done_s)              overrun_r <= 1'b0;
      busy_r <= (state_next_s != ST_IDLE);
    end
  end

  assign rx_data    = rx_data_r;
  assign rx_valid   = rx_valid_r;
  assign frame_err  = frame_err_r;
  assign parity_err = parity_err_r;
  assign overrun    = overrun_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_uart_rx_frac.sv
`timescale 1ns/1ps
// Bench for uart_rx_frac: directed frames at 8680 ns per bit; expected words
// are queued at stimulus time and a monitor checks them at each handshake.
module tb_uart_rx_frac;

  localparam int BIT_NS = 8680;

  logic       clk = 1'b0;
  logic       reset, rx_pin, parity_odd, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, overrun, busy;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       fe;
    logic       pe;
  } exp_t;
  exp_t exp_q[$];

  uart_rx_frac dut (
    .clk(clk), .reset(reset), .rx_pin(rx_pin), .parity_odd(parity_odd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Serialize one frame: start, 8 data bits LSB first, optional parity, stop.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_v);
    rx_pin = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      rx_pin = d[i];
      #(BIT_NS);
    end
`ifdef UART_RX_PARITY_EN
    rx_pin = par;
    #(BIT_NS);
`else
    if (par === 1'bx) rx_pin = 1'b1;
`endif
    rx_pin = stop_v;
    #(BIT_NS);
    rx_pin = 1'b1;
  endtask

  task automatic push(input logic [7:0] d, input logic fe, input logic pe);
    exp_t e;
    e.data = d;
    e.fe   = fe;
    e.pe   = pe;
    exp_q.push_back(e);
  endtask

  // Monitor: every handshake pops one expected word and compares it.
  always @(negedge clk) begin
    if (!reset && rx_valid && rx_ready) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word got data=%0h expected none", rx_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
        check("frame_err", {31'd0, frame_err}, {31'd0, e.fe});
        check("parity_err", {31'd0, parity_err}, {31'd0, e.pe});
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #(1000000);
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hs_before;
    int n_expected;
    logic seen_busy;
    logic fell;
    reset      = 1'b1;
    rx_pin     = 1'b1;
    rx_ready   = 1'b1;
    parity_odd = 1'b0;
    n_expected = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_parity_err", {31'd0, parity_err}, 32'd0);
    check("reset_overrun", {31'd0, overrun}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (100) @(posedge clk);

    // Plain frame 0xA5 (even parity bit 0).
    push(8'hA5, 1'b0, 1'b0);
    n_expected++;
    send_frame(8'hA5, 1'b0, 1'b1);
    #(BIT_NS);

    // 2000 ns low glitch: busy rises then falls, no word.
    hs_before = hs_count;
    seen_busy = 1'b0;
    fell      = 1'b0;
    rx_pin    = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
    end
    rx_pin = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) begin
        fell = 1'b1;
        break;
      end
    end
    check("glitch_busy_rose", {31'd0, seen_busy}, 32'd1);
    check("glitch_busy_fell", {31'd0, fell}, 32'd1);
    #(BIT_NS);
    check("glitch_no_word", hs_count, hs_before);

    // Bad stop bit on 0x3C.
    push(8'h3C, 1'b1, 1'b0);
    n_expected++;
    send_frame(8'h3C, 1'b0, 1'b0);
    #(2 * BIT_NS);

    // Overrun: hold off the consumer, send two words.
    @(posedge clk);
    #1 rx_ready = 1'b0;
    push(8'h11, 1'b0, 1'b0);
    n_expected++;
    send_frame(8'h11, 1'b0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1);
    #(BIT_NS);
    @(negedge clk);
    check("ovr_rx_valid_held", {31'd0, rx_valid}, 32'd1);
    check("ovr_rx_data_held", {24'd0, rx_data}, 32'h11);
    check("ovr_overrun_set", {31'd0, overrun}, 32'd1);
    @(posedge clk);
    #1 rx_ready = 1'b1;
    @(posedge clk);
    #1 rx_ready = 1'b0;
    @(negedge clk);
    check("ovr_rx_valid_clear", {31'd0, rx_valid}, 32'd0);
    check("ovr_overrun_clear", {31'd0, overrun}, 32'd0);
    @(posedge clk);
    #1 rx_ready = 1'b1;

`ifdef UART_RX_PARITY_EN
    // Even parity on 0x07: bit 1 is correct, bit 0 is an error.
    push(8'h07, 1'b0, 1'b0);
    n_expected++;
    send_frame(8'h07, 1'b1, 1'b1);
    push(8'h07, 1'b0, 1'b1);
    n_expected++;
    send_frame(8'h07, 1'b0, 1'b1);
    #(BIT_NS);
`endif

    // Reset during data bit 3 of 0x55, then a clean 0x81.
    rx_pin = 1'b0;
    #(BIT_NS);
    rx_pin = 1'b1;
    #(BIT_NS);
    rx_pin = 1'b0;
    #(BIT_NS);
    rx_pin = 1'b1;
    #(BIT_NS);
    rx_pin = 1'b0;
    #(BIT_NS / 2);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    rx_pin = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_rx_valid", {31'd0, rx_valid}, 32'd0);
    #(BIT_NS);
    push(8'h81, 1'b0, 1'b0);
    n_expected++;
    send_frame(8'h81, 1'b0, 1'b1);
    #(BIT_NS);

    check("queue_drained", exp_q.size(), 32'd0);
    check("word_count", hs_count, n_expected);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
